// File: rtl/fft_pkg.sv
// Shared FFT helpers: bit-reversal, constant log2 and the reorder reader state type.
package fft_pkg;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Smallest r with 2**r >= n; usable in constant expressions.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverse the low nbits of v; upper bits of the result are zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[i] = v[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_ram.sv
// Simple dual-port frame store with registered read. The bank select is the
// address MSB, so both ping-pong banks live in one block-RAM-inferable array.
module fft_bitrev_ram #(
  parameter int DATA_W = 50,
  parameter int ADDR_W = 11
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value while re is low (output stall)
  always_ff @(posedge clk_i) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts bit-reversed-order FFT output frames to natural order using a
// ping-pong pair of frame banks. Optional macro FFT_REORDER_INDEX_EN adds
// index_o carrying the bin number of the current output sample.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 25,
  parameter int FFT_LEN    = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         valid_i,
  input  logic signed [DATA_WIDTH-1:0] x_re_i,
  input  logic signed [DATA_WIDTH-1:0] x_im_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] z_re_o,
  output logic signed [DATA_WIDTH-1:0] z_im_o,
  output logic                         last_o,
  output logic                         overflow_o
`ifdef FFT_REORDER_INDEX_EN
  ,
  output logic [log2_ceil(FFT_LEN)-1:0] index_o
`endif
);

  localparam int             AW       = log2_ceil(FFT_LEN);
  localparam logic [AW-1:0]  LAST_BIN = AW'(FFT_LEN - 1);

  logic [AW-1:0]             w_cnt;
  logic                      w_bank;
  logic [AW-1:0]             wr_addr;
  rd_state_t                 r_state;
  logic [AW-1:0]             r_addr;
  logic                      r_bank;
  logic                      vld_p0;
  logic [AW-1:0]             bin_p0;
  logic [2*DATA_WIDTH-1:0]   rdata_p0;

  logic advance;
  logic rd_issue;
  logic rd_final;
  logic frame_done;
  logic swap_ok;

  // The whole read pipeline moves together whenever the output slot is free.
  // The reader is finished once its last address is fetched, so a new frame
  // may be swapped in on that same edge and follow with no bubble.
  assign advance    = !valid_o || ready_i;
  assign rd_issue   = (r_state == RD_READ) && advance;
  assign rd_final   = rd_issue && (r_addr == LAST_BIN);
  assign frame_done = valid_i && (w_cnt == LAST_BIN);
  assign swap_ok    = frame_done && ((r_state == RD_IDLE) || rd_final);
  assign wr_addr    = AW'(bit_reverse(32'(w_cnt), AW));

  fft_bitrev_ram #(
    .DATA_W (2*DATA_WIDTH),
    .ADDR_W (AW+1)
  ) u_ram (
    .clk_i (clk_i),
    .we    (valid_i),
    .waddr ({w_bank, wr_addr}),
    .wdata ({x_re_i, x_im_i}),
    .re    (rd_issue),
    .raddr ({r_bank, r_addr}),
    .rdata (rdata_p0)
  );

  // Writer: sample counter, bank ownership and sticky overflow on a dropped frame
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      w_cnt      <= '0;
      w_bank     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (valid_i) begin
      w_cnt <= w_cnt + AW'(1);
      if (frame_done) begin
        if (swap_ok) w_bank     <= ~w_bank;
        else         overflow_o <= 1'b1;
      end
    end
  end

  // Reader FSM: natural-order address generation over the filled bank
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RD_IDLE;
      r_addr  <= '0;
      r_bank  <= 1'b0;
    end else if (swap_ok) begin
      r_state <= RD_READ;
      r_addr  <= '0;
      r_bank  <= w_bank;
    end else if (rd_issue) begin
      r_addr <= r_addr + AW'(1);
      if (r_addr == LAST_BIN) r_state <= RD_IDLE;
    end
  end

  // Stage p0: tag the RAM read register with its valid and bin number
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      bin_p0 <= '0;
    end else if (advance) begin
      vld_p0 <= rd_issue;
      bin_p0 <= r_addr;
    end
  end

  // Output stage: registered sample, held while downstream stalls
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      z_re_o  <= '0;
      z_im_o  <= '0;
    end else if (advance) begin
      valid_o <= vld_p0;
      last_o  <= vld_p0 && (bin_p0 == LAST_BIN);
      z_re_o  <= rdata_p0[2*DATA_WIDTH-1:DATA_WIDTH];
      z_im_o  <= rdata_p0[DATA_WIDTH-1:0];
    end
  end

`ifdef FFT_REORDER_INDEX_EN
  // Bin number travelling with the output sample
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)       index_o <= '0;
    else if (advance) index_o <= bin_p0;
  end
`endif

endmodule
